// File: rtl/calc_disp_pkg.sv
// Shared calculator display types: FSM state encoding, segment word and blank pattern.
package calc_disp_pkg;

   typedef enum logic [2:0] {
      OP1_IN   = 3'b000,
      OP1_DONE = 3'b001,
      OP2_IN   = 3'b010,
      OP2_DONE = 3'b011,
      OPER     = 3'b100,
      RESULT   = 3'b101
   } calc_state_t;

   // {g,f,e,d,c,b,a}, active low
   typedef logic [6:0] seg7_t;

   localparam seg7_t SEG_OFF = 7'h7F;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low 7-segment decoder, letters shown as A b C d E F.
module hex_to_seg7
   import calc_disp_pkg::*;
(
   input  logic [3:0] hex,
   output logic [6:0] seg
);

   seg7_t dec;

   always_comb begin
      dec = SEG_OFF;
      case (hex)
         4'h0: dec = 7'b1000000;
         4'h1: dec = 7'b1111001;
         4'h2: dec = 7'b0100100;
         4'h3: dec = 7'b0110000;
         4'h4: dec = 7'b0011001;
         4'h5: dec = 7'b0010010;
         4'h6: dec = 7'b0000010;
         4'h7: dec = 7'b1111000;
         4'h8: dec = 7'b0000000;
         4'h9: dec = 7'b0010000;
         4'hA: dec = 7'b0001000;
         4'hB: dec = 7'b0000011;
         4'hC: dec = 7'b1000110;
         4'hD: dec = 7'b0100001;
         4'hE: dec = 7'b0000110;
         4'hF: dec = 7'b0001110;
         default: dec = SEG_OFF;
      endcase
   end

   assign seg = dec;

endmodule

// File: rtl/display_scan_ctrl.sv
// Calculator display selector driving an N-digit multiplexed active-low 7-segment display
// with frame latching, leading-zero blanking and operand-entry blinking.
module display_scan_ctrl
   import calc_disp_pkg::*;
#(
   parameter int unsigned DATA_W       = 16,
   parameter int unsigned REFRESH_DIV  = 100000,
   parameter int unsigned BLINK_FRAMES = 250
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [2:0]            state,
   input  logic [DATA_W-1:0]     op1,
   input  logic [DATA_W-1:0]     op2,
   input  logic [DATA_W-1:0]     operation,
   input  logic [DATA_W-1:0]     result,
   input  logic                  blank_lz,
   output logic [DATA_W-1:0]     display_value,
   output logic [DATA_W/4-1:0]   anodes_n,
   output logic [6:0]            segments_n
);

   localparam int unsigned N_DIGITS = DATA_W / 4;
   localparam int unsigned IDX_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam int unsigned REF_W    = $clog2(REFRESH_DIV);
   localparam int unsigned BLK_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [DATA_W-1:0]   sel_value;
   logic [DATA_W-1:0]   frame;
   logic [DATA_W-1:0]   upper;
   logic [IDX_W-1:0]    idx;
   logic [REF_W-1:0]    refresh_cnt;
   logic [BLK_W-1:0]    blink_cnt;
   logic                blink_phase;
   logic [2:0]          state_q;
   logic [3:0]          nibble;
   seg7_t               seg_dec;
   logic [N_DIGITS-1:0] digit_sel;
   logic                digit_tick;
   logic                scan_wrap;
   logic                state_changed;
   logic                lz_blank;
   logic                blink_blank;

   always_comb begin
      sel_value = '0;
      case (state)
         OP1_IN, OP1_DONE: sel_value = op1;
         OP2_IN, OP2_DONE: sel_value = op2;
         OPER:             sel_value = operation;
         RESULT:           sel_value = result;
         default:          sel_value = '0;
      endcase
   end

   always_comb begin
      digit_tick    = (refresh_cnt == REF_W'(REFRESH_DIV - 1));
      scan_wrap     = digit_tick && (idx == IDX_W'(N_DIGITS - 1));
      state_changed = (state != state_q);
      nibble        = frame[{idx, 2'b00} +: 4];
      // Digit is a leading zero when it and every more significant nibble are zero.
      upper         = frame >> {idx, 2'b00};
      lz_blank      = blank_lz && (idx != '0) && (upper == '0);
      // Suppress the stale phase on the cycle a state change clears it.
      blink_blank   = ((state == OP1_IN) || (state == OP2_IN)) && blink_phase && !state_changed;
      digit_sel     = '0;
      digit_sel[idx] = 1'b1;
   end

   hex_to_seg7 u_dec (
      .hex (nibble),
      .seg (seg_dec)
   );

   always_ff @(posedge clk) begin
      state_q <= state;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         display_value <= '0;
         frame         <= '0;
         idx           <= '0;
         refresh_cnt   <= '0;
         blink_cnt     <= '0;
         blink_phase   <= 1'b0;
         anodes_n      <= '1;
         segments_n    <= SEG_OFF;
      end else begin
         display_value <= sel_value;

         if (digit_tick) begin
            refresh_cnt <= '0;
            idx         <= (idx == IDX_W'(N_DIGITS - 1)) ? '0 : idx + 1'b1;
         end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
         end

         if (scan_wrap) begin
            frame <= display_value;
         end

         if (state_changed) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
         end else if (scan_wrap) begin
            if (blink_cnt == BLK_W'(BLINK_FRAMES - 1)) begin
               blink_cnt   <= '0;
               blink_phase <= ~blink_phase;
            end else begin
               blink_cnt <= blink_cnt + 1'b1;
            end
         end

         if (lz_blank || blink_blank) begin
            anodes_n   <= '1;
            segments_n <= SEG_OFF;
         end else begin
            anodes_n   <= ~digit_sel;
            segments_n <= seg_dec;
         end
      end
   end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with DATA_W=16, REFRESH_DIV=4, BLINK_FRAMES=2.
module tb_display_scan_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [2:0]  state = 3'b000;
   logic [15:0] op1 = '0;
   logic [15:0] op2 = '0;
   logic [15:0] operation = '0;
   logic [15:0] result = '0;
   logic        blank_lz = 1'b0;
   logic [15:0] display_value;
   logic [3:0]  anodes_n;
   logic [6:0]  segments_n;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;
   int          e = 0;

   logic [6:0]  exp_seg [4];
   logic [3:0]  exp_an;
   logic [3:0]  one;

   display_scan_ctrl #(
      .DATA_W       (16),
      .REFRESH_DIV  (4),
      .BLINK_FRAMES (2)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .state         (state),
      .op1           (op1),
      .op2           (op2),
      .operation     (operation),
      .result        (result),
      .blank_lz      (blank_lz),
      .display_value (display_value),
      .anodes_n      (anodes_n),
      .segments_n    (segments_n)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s (edge %0d): got %0h expected %0h", tag, e, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
      e++;
   endtask

   task automatic do_reset;
      reset = 1'b1;
      repeat (3) tick;
      reset = 1'b0;
      e = 0;
   endtask

   task automatic run_to(input int target);
      while (e < target) tick;
   endtask

   initial begin
      // 1: reset state
      do_reset();
      check("rst_an", 32'(anodes_n), 32'h0F);
      check("rst_seg", 32'(segments_n), 32'h7F);
      check("rst_dv", 32'(display_value), 32'h0);

      // 2: result 12AB scanned, mid-frame data change held off to next frame
      state = 3'b101; result = 16'h12AB; blank_lz = 1'b0;
      do_reset();
      tick;
      check("dv_result", 32'(display_value), 32'h12AB);
      exp_seg[0] = 7'h03; exp_seg[1] = 7'h08; exp_seg[2] = 7'h24; exp_seg[3] = 7'h79;
      run_to(16);
      for (int i = 0; i < 16; i++) begin
         tick;
         one = 4'b0001;
         exp_an = ~(one << (i / 4));
         check("scan_an", 32'(anodes_n), 32'(exp_an));
         check("scan_seg", 32'(segments_n), 32'(exp_seg[i / 4]));
         if (i == 3) result = 16'h0000;
      end
      tick;
      check("next_frame_seg", 32'(segments_n), 32'h40);

      // 3: op2 = 0005 with leading-zero blanking
      state = 3'b011; op2 = 16'h0005; blank_lz = 1'b1;
      do_reset();
      run_to(17);
      check("lz_d0_an", 32'(anodes_n), 32'h0E);
      check("lz_d0_seg", 32'(segments_n), 32'h12);
      run_to(21);
      check("lz_d1_an", 32'(anodes_n), 32'h0F);
      check("lz_d1_seg", 32'(segments_n), 32'h7F);
      run_to(29);
      check("lz_d3_an", 32'(anodes_n), 32'h0F);
      run_to(33);
      check("lz_wrap_an", 32'(anodes_n), 32'h0E);

      // 4: blinking while entering op1, then leave blinking state
      state = 3'b000; op1 = 16'h0005; blank_lz = 1'b0; result = 16'h00C0;
      do_reset();
      run_to(17);
      check("blk_vis_an", 32'(anodes_n), 32'h0E);
      check("blk_vis_seg", 32'(segments_n), 32'h12);
      run_to(32);
      check("blk_vis_end", 32'(anodes_n), 32'h07);
      run_to(33);
      check("blk_off_an", 32'(anodes_n), 32'h0F);
      check("blk_off_seg", 32'(segments_n), 32'h7F);
      run_to(64);
      check("blk_off_end", 32'(anodes_n), 32'h0F);
      run_to(65);
      check("blk_back_an", 32'(anodes_n), 32'h0E);
      check("blk_back_seg", 32'(segments_n), 32'h12);
      run_to(97);
      check("blk_off2_an", 32'(anodes_n), 32'h0F);
      run_to(100);
      state = 3'b101;
      tick;
      check("blk_exit_an", 32'(anodes_n), 32'h0D);
      check("blk_exit_seg", 32'(segments_n), 32'h40);
      check("blk_exit_dv", 32'(display_value), 32'h00C0);

      // 5: undefined state selects zero
      state = 3'b110; op1 = 16'h1234; result = 16'hFFFF; blank_lz = 1'b1;
      do_reset();
      tick;
      check("st110_dv", 32'(display_value), 32'h0);
      run_to(17);
      check("st110_d0_an", 32'(anodes_n), 32'h0E);
      check("st110_d0_seg", 32'(segments_n), 32'h40);
      run_to(25);
      check("st110_d2_an", 32'(anodes_n), 32'h0F);
      check("st110_d2_seg", 32'(segments_n), 32'h7F);

      // 6: reset mid-scan while digit 2 is active
      state = 3'b101; result = 16'h12AB; blank_lz = 1'b0;
      do_reset();
      run_to(10);
      reset = 1'b1;
      tick;
      check("mid_rst_an", 32'(anodes_n), 32'h0F);
      check("mid_rst_seg", 32'(segments_n), 32'h7F);
      check("mid_rst_dv", 32'(display_value), 32'h0);
      reset = 1'b0;
      e = 0;
      for (int i = 0; i < 4; i++) begin
         tick;
         check("restart_d0", 32'(anodes_n), 32'h0E);
      end
      tick;
      check("restart_d1", 32'(anodes_n), 32'h0D);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
Parametrised successor of the calculator display selector. It picks the value to show from the calculator FSM state and registers it. It then drives an N-digit multiplexed active-low 7-segment display with a refresh scan, tear-free frame latching, optional leading-zero blanking, and blinking while an operand is being entered. It sits between the calculator FSM/datapath and the board display pins.

Parameters:
DATA_W, 16, width of op1/op2/operation/result; must be a multiple of 4; N_DIGITS = DATA_W/4 (derived localparam)
REFRESH_DIV, 100000, clk cycles each digit is driven (≥2)
BLINK_FRAMES, 250, full scan frames per blink half-period (≥1)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
state  input  3  calculator FSM state (encoding in shared package)
op1  input  DATA_W  first operand
op2  input  DATA_W  second operand
operation  input  DATA_W  operation code/display word
result  input  DATA_W  ALU result
blank_lz  input  1  1 = blank leading zero digits
display_value  output  DATA_W  registered selected value
anodes_n  output  N_DIGITS  digit enables, active low, one-hot-low when lit
segments_n  output  7  {g,f,e,d,c,b,a}, active low

Behaviour:
- One clock (clk). Reset is synchronous and active-high. All state is updated on the rising edge of clk.
- Reset values: display_value=0, frame=0, digit idx=0, refresh cnt=0, blink cnt=0, blink phase=0, anodes_n=all 1, segments_n=7'h7F.
- Source select, registered with 1-cycle latency:
  - state 100 → operation
  - state 000/001 → op1
  - state 010/011 → op2
  - state 101 → result
  - any other state → 0
- Refresh cnt counts 0..REFRESH_DIV-1 and wraps. At terminal count, idx advances; it wraps from N_DIGITS-1 to 0.
- Frame latch: frame ← display_value on the cycle refresh cnt is terminal and idx=N_DIGITS-1, i.e. when the scan wraps to digit 0. A whole frame therefore shows one consistent value, with no tearing.
- Decode: nibble = frame[4*idx+3 : 4*idx], hex 0-F. Letter forms are A, b, C, d, E, F.
- Leading-zero blanking:
  - When blank_lz=1, digit k is blanked if all nibbles at positions ≥k are 0 and k>0.
  - Digit 0 is never blanked by this rule, so value 0 shows "0".
- Blink:
  - Blinking states are 000 and 010.
  - Blink cnt counts completed frames 0..BLINK_FRAMES-1. On wrap it toggles the blink phase.
  - In a blinking state with phase=1, all digits are blanked.
  - Any change of state clears blink cnt and phase, so the display is visible immediately.
- Output register:
  - anodes_n/segments_n are registered; they reflect idx/frame/blank conditions 1 cycle later.
  - A blanked digit drives anodes_n all 1 and segments_n=7'h7F.
  - Otherwise only bit idx of anodes_n is low.
- Reset mid-scan: outputs return to reset values on the next edge. The scan restarts at digit 0 with a full REFRESH_DIV dwell.
- Simultaneous events: a state change in the same cycle as a blink wrap means the clear wins. Data changes mid-frame appear at the next frame boundary only.

Decomposition:
- Package calc_disp_pkg holds:
  - typedef enum logic[2:0] calc_state_t, with values OP1_IN=000, OP1_DONE=001, OP2_IN=010, OP2_DONE=011, OPER=100, RESULT=101
  - seg7_t typedef
  - blank constant SEG_OFF=7'h7F
- One sub-module: hex_to_seg7, a combinational 4-bit→7-segment active-low decoder.

Test Plan:
1. Use DATA_W=16, REFRESH_DIV=4, BLINK_FRAMES=2 for all scenarios. Hold reset 3 cycles → anodes_n=4'hF, segments_n=7'h7F, display_value=0.
2. state=101, result=16'h12AB, blank_lz=0 → display_value=16'h12AB one cycle later. From the next frame:
   - anodes_n sequence 1110,1101,1011,0111, 4 cycles each, wrapping
   - segments_n for digit 0 = 7'b0000011 ("b")
3. state=011, op2=16'h0005, blank_lz=1 → only digit 0 lit with segments_n=7'b0010010; digits 1-3 give anodes_n all 1.
4. state=000, op1=16'h0005 → 32 cycles (2 frames) visible, then 32 cycles all anodes_n high, alternating. Switch state to 101 during the blanked half → visible again 1 cycle later.
5. state=110 → display_value=0. With blank_lz=1, digit 0 shows 7'b1000000 and the others are blank.
6. Assert reset while idx=2 → next edge gives anodes_n=4'hF and display_value=0. After release, digit 0 is driven first for 4 cycles.
